// File: rtl/led_serial_driver_pkg.sv
// rtl/led_serial_driver_pkg.sv - shared state encoding and default geometry for the LED serial driver
package led_serial_driver_pkg;

    // Transfer sequencing states, 3-bit encoding shared with the SPIO side
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    localparam int DEF_DATA_BITS  = 16;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_CLR_CYCLES = 2;

endpackage

// File: rtl/led_serial_driver_if.sv
// rtl/led_serial_driver_if.sv - request and external shift-register pins of the LED serial driver
import led_serial_driver_pkg::*;

interface led_serial_driver_if #(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();
    logic                 Start;
    logic [DATA_BITS-1:0] PData;
    logic                 sclk;
    logic                 sout;
    logic                 sclrn;
    logic                 EN;
    logic                 busy;
    logic                 done;

    modport master (
        output Start, PData,
        input  sclk, sout, sclrn, EN, busy, done
    );

    modport slave (
        input  Start, PData,
        output sclk, sout, sclrn, EN, busy, done
    );
endinterface

// File: rtl/led_serial_driver_p2s_phase_counter.sv
// rtl/led_serial_driver_p2s_phase_counter.sv - loadable down-counter timing clear and sclk phases
module p2s_phase_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] count;

    // Load on phase entry, then count down and park at zero (terminal count)
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/led_serial_driver.sv
// rtl/led_serial_driver.sv - serialises the LED word onto the external shift register with clear/latch
import led_serial_driver_pkg::*;

module led_serial_driver #(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    led_serial_driver_if.slave  bus
);
    localparam int CNT_MAX = (CLR_CYCLES > CLK_DIV) ? CLR_CYCLES : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    state_t               state;
    state_t               state_n;
    logic                 start_q;
    logic                 start_edge;
    logic                 pending;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] pend_reg;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_val;
    logic                 cnt_tc;

    // start_q resets low so a Start already high at reset release still reads as an edge
    assign start_edge = bus.Start & ~start_q;

    p2s_phase_counter #(
        .WIDTH (CNT_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and phase-counter reloads; each timed phase reloads the counter on entry
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_n  = ST_CLEAR;
                    cnt_load = 1'b1;
                    cnt_val  = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (cnt_tc) begin
                    state_n  = ST_SHIFT_LO;
                    cnt_load = 1'b1;
                    cnt_val  = DIV_LOAD;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_tc) begin
                    state_n  = ST_SHIFT_HI;
                    cnt_load = 1'b1;
                    cnt_val  = DIV_LOAD;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_tc) begin
                    if (bit_cnt == '0) begin
                        state_n = ST_LATCH;
                    end else begin
                        state_n  = ST_SHIFT_LO;
                        cnt_load = 1'b1;
                        cnt_val  = DIV_LOAD;
                    end
                end
            end
            ST_LATCH: begin
                if (pending || start_edge) begin
                    state_n  = ST_CLEAR;
                    cnt_load = 1'b1;
                    cnt_val  = CLR_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Capture, shifting, bit counting and the one-deep request buffer (last request wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            shift_reg <= '0;
            pend_reg  <= '0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            start_q <= bus.Start;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        shift_reg <= bus.PData;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_tc) begin
                        bit_cnt <= BIT_LAST;
                    end
                end
                ST_SHIFT_HI: begin
                    if (cnt_tc) begin
                        shift_reg <= shift_reg << 1;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    // A request arriving in the latch cycle is newer than any buffered one
                    if (start_edge) begin
                        shift_reg <= bus.PData;
                    end else if (pending) begin
                        shift_reg <= pend_reg;
                    end
                    pending <= 1'b0;
                end
                default: ;
            endcase
            if (start_edge && (state != ST_IDLE) && (state != ST_LATCH)) begin
                pend_reg <= bus.PData;
                pending  <= 1'b1;
            end
        end
    end

    // Registered pin drivers decoded from the current state, so the board pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sclk  <= 1'b0;
            bus.sout  <= 1'b0;
            bus.sclrn <= 1'b1;
            bus.EN    <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.sclk  <= (state == ST_SHIFT_HI);
            bus.sout  <= ((state == ST_SHIFT_LO) || (state == ST_SHIFT_HI)) ?
                         shift_reg[DATA_BITS-1] : 1'b0;
            bus.sclrn <= (state != ST_CLEAR);
            bus.EN    <= (state == ST_LATCH);
            bus.done  <= (state == ST_LATCH);
            bus.busy  <= (state != ST_IDLE) || start_edge;
        end
    end
endmodule

// File: tb/tb_led_serial_driver.sv
// tb/tb_led_serial_driver.sv - scoreboard bench for led_serial_driver
module tb_led_serial_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   en_cnt_a = 0;

    typedef struct {
        logic [15:0] word;
        int          en_cyc;
    } sb_t;

    sb_t exp_a[$];
    sb_t exp_b[$];

    led_serial_driver_if #(.DATA_BITS(16)) bus_a ();
    led_serial_driver_if #(.DATA_BITS(8))  bus_b ();

    led_serial_driver dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    led_serial_driver #(
        .DATA_BITS  (8),
        .CLK_DIV    (1),
        .CLR_CYCLES (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: reassembles the word from sclk rises and checks each EN against the scoreboard
    initial begin
        logic        prev_sclk = 1'b0;
        logic        prev_sout = 1'b0;
        logic        prev_sclrn = 1'b1;
        logic [15:0] col = '0;
        int          nbits = 0;
        int          clr_run = 0;
        sb_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                col = '0; nbits = 0; clr_run = 0;
                prev_sclk = 1'b0; prev_sout = 1'b0; prev_sclrn = 1'b1;
            end else begin
                if (bus_a.sclk && !prev_sclk) begin
                    col = {col[14:0], bus_a.sout};
                    nbits++;
                end
                if (bus_a.sclk && prev_sclk) check("a_sout_hold_while_sclk_high", bus_a.sout, prev_sout);
                check("a_done_matches_en", bus_a.done, bus_a.EN);
                if (!bus_a.sclrn) clr_run++;
                else if (!prev_sclrn) begin
                    check("a_sclrn_low_len", clr_run, 2);
                    clr_run = 0;
                end
                if (bus_a.EN) begin
                    en_cnt_a++;
                    check("a_busy_at_en", bus_a.busy, 1);
                    check("a_en_expected", exp_a.size() != 0, 1);
                    if (exp_a.size() != 0) begin
                        e = exp_a.pop_front();
                        check("a_word", col, e.word);
                        check("a_sclk_rises", nbits, 16);
                        check("a_en_cycle", cyc, e.en_cyc);
                    end
                    col = '0;
                    nbits = 0;
                end
                prev_sclk = bus_a.sclk; prev_sout = bus_a.sout; prev_sclrn = bus_a.sclrn;
            end
        end
    end

    // Monitor B: the 8-bit, fastest-timing instance
    initial begin
        logic       prev_sclk = 1'b0;
        logic       prev_sclrn = 1'b1;
        logic [7:0] col = '0;
        int         nbits = 0;
        int         ones = 0;
        int         clr_run = 0;
        sb_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                col = '0; nbits = 0; ones = 0; clr_run = 0;
                prev_sclk = 1'b0; prev_sclrn = 1'b1;
            end else begin
                if (bus_b.sclk && !prev_sclk) begin
                    col = {col[6:0], bus_b.sout};
                    nbits++;
                    if (bus_b.sout) ones++;
                end
                if (!bus_b.sclrn) clr_run++;
                else if (!prev_sclrn) begin
                    check("b_sclrn_low_len", clr_run, 1);
                    clr_run = 0;
                end
                if (bus_b.EN) begin
                    check("b_done_at_en", bus_b.done, 1);
                    check("b_en_expected", exp_b.size() != 0, 1);
                    if (exp_b.size() != 0) begin
                        e = exp_b.pop_front();
                        check("b_word", col, e.word);
                        check("b_sclk_rises", nbits, 8);
                        check("b_sout_high_rises", ones, 1);
                        check("b_en_cycle", cyc, e.en_cyc);
                    end
                    col = '0; nbits = 0; ones = 0;
                end
                prev_sclk = bus_b.sclk; prev_sclrn = bus_b.sclrn;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_a.size() + exp_b.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int drops;
        int en0;
        bus_a.Start = 1'b0; bus_a.PData = '0;
        bus_b.Start = 1'b0; bus_b.PData = '0;
        repeat (3) @(negedge clk);
        check("a_reset_outputs", {bus_a.sclk, bus_a.sout, bus_a.sclrn, bus_a.EN, bus_a.busy, bus_a.done}, 6'b001000);
        check("b_reset_outputs", {bus_b.sclk, bus_b.sout, bus_b.sclrn, bus_b.EN, bus_b.busy, bus_b.done}, 6'b001000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single A5A5 transfer, EN at +67 after the capture edge
        c = cyc;
        exp_a.push_back('{16'hA5A5, c + 68});
        bus_a.Start = 1'b1; bus_a.PData = 16'hA5A5;
        @(negedge clk);
        bus_a.Start = 1'b0;
        check("a_busy_after_capture", bus_a.busy, 1);
        wait_drain(200);
        check("a_idle_busy", bus_a.busy, 0);

        // 2: Start held 200 cycles, PData changed after capture -> one transfer of the captured word
        en0 = en_cnt_a;
        c = cyc;
        exp_a.push_back('{16'h3C3C, c + 68});
        bus_a.Start = 1'b1; bus_a.PData = 16'h3C3C;
        repeat (5) @(negedge clk);
        bus_a.PData = 16'hDEAD;
        repeat (195) @(negedge clk);
        bus_a.Start = 1'b0;
        wait_drain(200);
        repeat (20) @(negedge clk);
        check("a_held_start_one_en", en_cnt_a - en0, 1);

        // 3: two edges during a transfer, last one wins, back-to-back without busy dropping
        c = cyc; drops = 0;
        exp_a.push_back('{16'hA5A5, c + 68});
        exp_a.push_back('{16'hFFFF, c + 135});
        while (cyc < c + 136) begin
            case (cyc - c)
                0:  begin bus_a.Start = 1'b1; bus_a.PData = 16'hA5A5; end
                10: begin bus_a.Start = 1'b1; bus_a.PData = 16'h1234; end
                20: begin bus_a.Start = 1'b1; bus_a.PData = 16'hFFFF; end
                default: bus_a.Start = 1'b0;
            endcase
            @(negedge clk);
            if (cyc - c >= 1 && cyc - c <= 135 && !bus_a.busy) drops++;
        end
        bus_a.Start = 1'b0;
        check("a_busy_drops_back_to_back", drops, 0);
        wait_drain(200);

        // 4: edge sampled in the LATCH cycle starts the next transfer immediately
        c = cyc;
        exp_a.push_back('{16'hA5A5, c + 68});
        exp_a.push_back('{16'h0001, c + 135});
        while (cyc < c + 136) begin
            case (cyc - c)
                0:  begin bus_a.Start = 1'b1; bus_a.PData = 16'hA5A5; end
                67: begin bus_a.Start = 1'b1; bus_a.PData = 16'h0001; end
                default: bus_a.Start = 1'b0;
            endcase
            @(negedge clk);
        end
        bus_a.Start = 1'b0;
        wait_drain(200);

        // 5: reset mid-transfer aborts with no EN; a later request transfers cleanly
        c = cyc;
        exp_a.push_back('{16'hA5A5, c + 68});
        bus_a.Start = 1'b1; bus_a.PData = 16'hA5A5;
        @(negedge clk);
        bus_a.Start = 1'b0;
        while (cyc < c + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("a_outputs_after_mid_reset", {bus_a.sclk, bus_a.sout, bus_a.sclrn, bus_a.EN, bus_a.busy, bus_a.done}, 6'b001000);
        rst = 1'b0;
        exp_a.delete();
        en0 = en_cnt_a;
        repeat (100) @(negedge clk);
        check("a_no_en_after_abort", en_cnt_a - en0, 0);
        c = cyc;
        exp_a.push_back('{16'h5A0F, c + 68});
        bus_a.Start = 1'b1; bus_a.PData = 16'h5A0F;
        @(negedge clk);
        bus_a.Start = 1'b0;
        wait_drain(200);

        // 6: 8-bit, CLK_DIV=1, CLR_CYCLES=1 instance, EN at +18
        c = cyc;
        exp_b.push_back('{16'h0080, c + 19});
        bus_b.Start = 1'b1; bus_b.PData = 8'h80;
        @(negedge clk);
        bus_b.Start = 1'b0;
        wait_drain(100);
        check("b_idle_busy", bus_b.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
